// File: rtl/frame_burst_arbiter_pkg.sv
// frame_burst_arbiter_pkg: shared FSM encoding, frame buffer bases and offset wrap helper
package frame_burst_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WR_ACTIVE = 2'd1,
        RD_ACTIVE = 2'd2
    } state_t;

    localparam logic BUF_0 = 1'b0;
    localparam logic BUF_1 = 1'b1;

    function automatic logic [31:0] buf_base(input logic sel, input logic [31:0] frame_words);
        return (sel == BUF_1) ? frame_words : 32'd0;
    endfunction

    function automatic logic [31:0] next_offset(input logic [31:0] offset, input logic [31:0] burst_len,
                                                input logic [31:0] frame_words);
        return (offset + burst_len == frame_words) ? 32'd0 : offset + burst_len;
    endfunction

endpackage

// File: rtl/frame_burst_arbiter_addr_gen.sv
// burst_addr_gen: per-channel frame offset with wrap, deferred frame restart and frame-complete strobe
module burst_addr_gen
    import frame_burst_arbiter_pkg::*;
#(
    parameter int BURST_LEN   = 128,
    parameter int FRAME_WORDS = 1024 * 768 / 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        active,
    input  logic        finish,
    input  logic        frame_start,
    output logic [31:0] offset,
    output logic        restart,
    output logic        frame_done
);

    logic pending;
    logic done;

    assign done       = active && finish;
    // a frame start seen while bursting only takes effect once that burst completes
    assign restart    = (frame_start && !active) || (done && (pending || frame_start));
    assign frame_done = done && (offset + 32'(BURST_LEN) == 32'(FRAME_WORDS));

    always_ff @(posedge clk) begin
        if (rst) begin
            offset  <= '0;
            pending <= 1'b0;
        end else begin
            if (restart)
                offset <= '0;
            else if (done)
                offset <= next_offset(offset, 32'(BURST_LEN), 32'(FRAME_WORDS));
            pending <= active && !finish && (pending || frame_start);
        end
    end

endmodule

// File: rtl/frame_burst_arbiter.sv
// frame_burst_arbiter: round-robin camera-write / LCD-read DDR burst scheduler with frame addressing.
// Define FRAME_BUFFER_PINGPONG_EN for double-buffered frames (bases 0 and FRAME_WORDS).
module frame_burst_arbiter
    import frame_burst_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH    = 25,
    parameter int BURST_LEN     = 128,
    parameter int FRAME_WORDS   = 1024 * 768 / 2,
    parameter int LEVEL_W       = 10,
    parameter int RD_FIFO_DEPTH = 1024
) (
    input  logic                  mem_clk,
    input  logic                  rst,
    input  logic                  local_init_done,
    input  logic                  wr_frame_start,
    input  logic                  rd_frame_start,
    input  logic [LEVEL_W-1:0]    wr_fifo_level,
    input  logic [LEVEL_W-1:0]    rd_fifo_level,
    output logic                  wr_burst_req,
    output logic [9:0]            wr_burst_len,
    output logic [ADDR_WIDTH-1:0] wr_burst_addr,
    input  logic                  wr_burst_finish,
    output logic                  rd_burst_req,
    output logic [9:0]            rd_burst_len,
    output logic [ADDR_WIDTH-1:0] rd_burst_addr,
    input  logic                  rd_burst_finish,
    output logic                  wr_busy,
    output logic                  rd_busy
);

    state_t      state;
    logic        last_rd;
    logic        wr_ok_q;
    logic        rd_ok_q;
    logic [31:0] wr_offset;
    logic [31:0] rd_offset;
    logic [31:0] wr_base;
    logic [31:0] rd_base;
    logic        wr_restart;
    logic        rd_restart;
    logic        wr_done;
    logic        rd_done;

    assign wr_burst_len  = 10'(BURST_LEN);
    assign rd_burst_len  = 10'(BURST_LEN);
    assign wr_burst_addr = ADDR_WIDTH'(wr_base + wr_offset);
    assign rd_burst_addr = ADDR_WIDTH'(rd_base + rd_offset);
    assign wr_busy       = wr_burst_req;
    assign rd_busy       = rd_burst_req;

    burst_addr_gen #(.BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS)) u_wr_gen (
        .clk(mem_clk), .rst(rst), .active(state == WR_ACTIVE), .finish(wr_burst_finish),
        .frame_start(wr_frame_start), .offset(wr_offset), .restart(wr_restart), .frame_done(wr_done)
    );

    burst_addr_gen #(.BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS)) u_rd_gen (
        .clk(mem_clk), .rst(rst), .active(state == RD_ACTIVE), .finish(rd_burst_finish),
        .frame_start(rd_frame_start), .offset(rd_offset), .restart(rd_restart), .frame_done(rd_done)
    );

`ifdef FRAME_BUFFER_PINGPONG_EN
    logic wr_buf;
    logic rd_buf;
    logic done_buf;
    logic unused_gen;

    // reader follows the newest complete frame; writer always takes the other buffer
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            wr_buf   <= BUF_0;
            rd_buf   <= BUF_0;
            done_buf <= BUF_0;
        end else begin
            if (wr_restart) wr_buf <= ~rd_buf;
            if (rd_restart) rd_buf <= wr_done ? wr_buf : done_buf;
            if (wr_done) done_buf <= wr_buf;
        end
    end

    assign wr_base    = buf_base(wr_buf, 32'(FRAME_WORDS));
    assign rd_base    = buf_base(rd_buf, 32'(FRAME_WORDS));
    assign unused_gen = rd_done;
`else
    logic unused_gen;

    assign wr_base    = '0;
    assign rd_base    = '0;
    assign unused_gen = &{1'b0, wr_restart, rd_restart, wr_done, rd_done};
`endif

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_burst_req <= 1'b0;
            rd_burst_req <= 1'b0;
            last_rd      <= 1'b1;
            wr_ok_q      <= 1'b0;
            rd_ok_q      <= 1'b0;
        end else begin
            wr_ok_q <= local_init_done && (32'(wr_fifo_level) >= 32'(BURST_LEN));
            rd_ok_q <= local_init_done && (32'(rd_fifo_level) <= 32'(RD_FIFO_DEPTH - BURST_LEN));
            case (state)
                IDLE: begin
                    if (local_init_done && wr_ok_q && (!rd_ok_q || last_rd)) begin
                        state        <= WR_ACTIVE;
                        wr_burst_req <= 1'b1;
                        last_rd      <= 1'b0;
                    end else if (local_init_done && rd_ok_q) begin
                        state        <= RD_ACTIVE;
                        rd_burst_req <= 1'b1;
                        last_rd      <= 1'b1;
                    end
                end
                WR_ACTIVE: begin
                    if (wr_burst_finish) begin
                        state        <= IDLE;
                        wr_burst_req <= 1'b0;
                    end
                end
                RD_ACTIVE: begin
                    if (rd_burst_finish) begin
                        state        <= IDLE;
                        rd_burst_req <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_burst_arbiter.sv
// tb_frame_burst_arbiter: directed stimulus, per-cycle reference model plus literal expectations
module tb_frame_burst_arbiter;

    localparam int BL    = 128;
    localparam int FW    = 512;
    localparam int AW    = 25;
    localparam int LW    = 10;
    localparam int DEPTH = 1024;
`ifdef FRAME_BUFFER_PINGPONG_EN
    localparam int PP = 1;
`else
    localparam int PP = 0;
`endif

    logic          mem_clk = 1'b0;
    logic          rst;
    logic          local_init_done;
    logic          wr_frame_start;
    logic          rd_frame_start;
    logic [LW-1:0] wr_fifo_level;
    logic [LW-1:0] rd_fifo_level;
    logic          wr_burst_req;
    logic          rd_burst_req;
    logic [9:0]    wr_burst_len;
    logic [9:0]    rd_burst_len;
    logic [AW-1:0] wr_burst_addr;
    logic [AW-1:0] rd_burst_addr;
    logic          wr_burst_finish;
    logic          rd_burst_finish;
    logic          wr_busy;
    logic          rd_busy;

    int checks = 0;
    int errors = 0;
    int fin_lat = 20;
    int log_t[$];
    int log_a[$];
    logic prev_w = 1'b0;
    logic prev_r = 1'b0;

    int m_ch, m_woff, m_roff, m_wbuf, m_rbuf, m_done;
    bit m_last_r, m_wokq, m_rokq, m_wpend, m_rpend;

    frame_burst_arbiter #(
        .ADDR_WIDTH(AW), .BURST_LEN(BL), .FRAME_WORDS(FW), .LEVEL_W(LW), .RD_FIFO_DEPTH(DEPTH)
    ) dut (
        .mem_clk(mem_clk), .rst(rst), .local_init_done(local_init_done),
        .wr_frame_start(wr_frame_start), .rd_frame_start(rd_frame_start),
        .wr_fifo_level(wr_fifo_level), .rd_fifo_level(rd_fifo_level),
        .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
        .wr_burst_finish(wr_burst_finish),
        .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
        .rd_burst_finish(rd_burst_finish), .wr_busy(wr_busy), .rd_busy(rd_busy)
    );

    always #5 mem_clk = ~mem_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int lt(input int i);
        return (i < log_t.size()) ? log_t[i] : -1;
    endfunction

    function automatic int la(input int i);
        return (i < log_a.size()) ? log_a[i] : -1;
    endfunction

    // channel: 0 none, 1 write, 2 read; buffers are indices 0/1 scaled by FW
    task automatic model_step();
        int ch, ow, orb;
        bit rw, rr, wrap;
        if (rst) begin
            m_ch = 0; m_last_r = 1; m_wokq = 0; m_rokq = 0; m_woff = 0; m_roff = 0;
            m_wpend = 0; m_rpend = 0; m_wbuf = 0; m_rbuf = 0; m_done = 0;
            return;
        end
        ch = m_ch; rw = 0; rr = 0; wrap = 0; ow = m_wbuf; orb = m_rbuf;
        if (m_ch == 0 && local_init_done) begin
            if (m_wokq && (!m_rokq || m_last_r)) begin ch = 1; m_last_r = 0; end
            else if (m_rokq) begin ch = 2; m_last_r = 1; end
        end
        if (m_ch == 1 && wr_burst_finish) begin
            ch = 0;
            wrap = (m_woff + BL == FW);
            if (m_wpend || wr_frame_start) rw = 1;
            else m_woff = (m_woff + BL) % FW;
            m_wpend = 0;
        end else if (wr_frame_start) begin
            if (m_ch == 1) m_wpend = 1;
            else rw = 1;
        end
        if (m_ch == 2 && rd_burst_finish) begin
            ch = 0;
            if (m_rpend || rd_frame_start) rr = 1;
            else m_roff = (m_roff + BL) % FW;
            m_rpend = 0;
        end else if (rd_frame_start) begin
            if (m_ch == 2) m_rpend = 1;
            else rr = 1;
        end
        if (rw) m_woff = 0;
        if (rr) m_roff = 0;
        if (PP == 1) begin
            if (rr) m_rbuf = wrap ? ow : m_done;
            if (rw) m_wbuf = 1 - orb;
            if (wrap) m_done = ow;
        end
        m_wokq = local_init_done && (wr_fifo_level >= BL);
        m_rokq = local_init_done && (rd_fifo_level <= DEPTH - BL);
        m_ch = ch;
    endtask

    initial begin
        forever begin
            @(posedge mem_clk);
            model_step();
            #1;
            chk("wr_req", wr_burst_req, m_ch == 1);
            chk("rd_req", rd_burst_req, m_ch == 2);
            chk("wr_busy", wr_busy, m_ch == 1);
            chk("rd_busy", rd_busy, m_ch == 2);
            chk("wr_len", wr_burst_len, BL);
            chk("rd_len", rd_burst_len, BL);
            if (m_ch == 1) chk("wr_addr", wr_burst_addr, m_wbuf * FW + m_woff);
            if (m_ch == 2) chk("rd_addr", rd_burst_addr, m_rbuf * FW + m_roff);
            if (wr_burst_req && !prev_w) begin log_t.push_back(0); log_a.push_back(int'(wr_burst_addr)); end
            if (rd_burst_req && !prev_r) begin log_t.push_back(1); log_a.push_back(int'(rd_burst_addr)); end
            prev_w = wr_burst_req;
            prev_r = rd_burst_req;
        end
    end

    // memory-side responder: completes every burst fin_lat cycles after its request
    initial begin
        int wc = 0, rc = 0;
        wr_burst_finish = 1'b0;
        rd_burst_finish = 1'b0;
        forever begin
            @(negedge mem_clk);
            wr_burst_finish = 1'b0;
            rd_burst_finish = 1'b0;
            wc = wr_burst_req ? wc + 1 : 0;
            rc = rd_burst_req ? rc + 1 : 0;
            if (wc == fin_lat) begin wr_burst_finish = 1'b1; wc = 0; end
            if (rc == fin_lat) begin rd_burst_finish = 1'b1; rc = 0; end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge mem_clk);
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int c = 0;
        while (log_t.size() < n && c < budget) begin tick(1); c++; end
        chk({name, "_timeout"}, log_t.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while ((wr_busy || rd_busy) && c < budget) begin tick(1); c++; end
        chk("idle_timeout", {wr_busy, rd_busy}, 0);
    endtask

    task automatic pulse_wfs();
        wr_frame_start = 1'b1;
        tick(1);
        wr_frame_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; local_init_done = 1'b0; wr_frame_start = 1'b0; rd_frame_start = 1'b0;
        wr_fifo_level = 200; rd_fifo_level = 1000;
        tick(3); rst = 1'b0; tick(5);
        chk("no_req_before_init", wr_burst_req, 0);
        local_init_done = 1'b1;
        tick(1); chk("req_one_cycle", wr_burst_req, 0);
        tick(1); chk("req_two_cycles", wr_burst_req, 1);
        chk("first_addr", wr_burst_addr, 0);
        rd_fifo_level = 0;
        wait_log(4, 200, "alternate");
        rd_fifo_level = 1000;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_type%0d", i), lt(i), i % 2);
            chk($sformatf("rr_addr%0d", i), la(i), (i / 2) * BL);
        end
        wait_log(7, 200, "wrap");
        wr_fifo_level = 0;
        chk("addr_256", la(4), 256);
        chk("addr_384", la(5), 384);
        chk("wrap_addr", la(6), 0);
        wait_idle(100);
        pulse_wfs();
        wr_fifo_level = 200;
        wait_log(8, 50, "after_fs");
        chk("fs_idle_addr", la(7), PP ? FW : 0);
        wait_log(10, 200, "to_256");
        chk("mid_addr_256", la(9), (PP ? FW : 0) + 256);
        tick(3);
        pulse_wfs();
        wait_log(11, 100, "after_mid_fs");
        wr_fifo_level = 0;
        chk("mid_fs_addr", la(10), PP ? FW : 0);
        wait_idle(100);
        rd_fifo_level = 900;
        tick(30);
        chk("rd_900_none", log_t.size(), 11);
        chk("rd_900_req", rd_burst_req, 0);
        rd_fifo_level = 896;
        wait_log(12, 10, "rd_896");
        chk("rd_896_type", lt(11), 1);
        chk("rd_896_addr", la(11), 256);
        rd_fifo_level = 1000;
        tick(4);
        rst = 1'b1;
        tick(1);
        chk("rst_rd_req", rd_burst_req, 0);
        chk("rst_rd_addr", rd_burst_addr, 0);
        tick(1);
        rst = 1'b0;
        tick(2);
        pulse_wfs();
        wr_fifo_level = 200;
        wait_log(16, 300, "pp_frame");
        wr_fifo_level = 0;
        chk("pp_first_addr", la(12), PP ? FW : 0);
        chk("pp_last_addr", la(15), (PP ? FW : 0) + 384);
        wait_idle(100);
        rd_frame_start = 1'b1;
        tick(1);
        rd_frame_start = 1'b0;
        rd_fifo_level = 0;
        wait_log(17, 50, "rd_pp");
        chk("rd_pp_type", lt(16), 1);
        chk("rd_pp_addr", la(16), PP ? FW : 0);
        rd_fifo_level = 1000;
        wait_idle(100);
        tick(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
